// File: rtl/dis_pal_pkg.sv
// dis_pal_pkg: shared types, word layout and PAL defaults
// for the PAL capture path.
package dis_pal_pkg;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_WAIT,
    ST_ACTIVE,
    ST_DROP
  } cap_state_e;

  typedef enum logic [1:0] {
    SK_NONE,
    SK_LINE,
    SK_BROAD
  } sync_kind_e;

  localparam int SYNC_CW = 10;

  localparam int PAL_LINE_TOTAL = 864;
  localparam int PAL_ACTIVE_X   = 720;
  localparam int PAL_ACTIVE_Y   = 288;
  localparam int PAL_H_OFFSET   = 126;

  // Stream word is {sop, eop, data}.
  function automatic int fw_sop_bit(input int dw);
    return dw + 1;
  endfunction

  function automatic int fw_eop_bit(input int dw);
    return dw;
  endfunction

  function automatic sync_kind_e classify_sync(
    input logic [SYNC_CW-1:0] w,
    input int                 hmin,
    input int                 vmin
  );
    int wi;
    wi = int'(w);
    if (wi >= vmin) return SK_BROAD;
    if (wi >= hmin) return SK_LINE;
    return SK_NONE;
  endfunction

endpackage

// File: rtl/dis_pal_capture_fifo.sv
// dis_pal_capture_fifo: single-clock show-ahead FIFO,
// read word is forced to zero while empty.
module dis_pal_capture_fifo #(
  parameter int  WIDTH = 12,
  parameter int  DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      usedw,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_wr, do_rd;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign usedw = cnt_q;

  // Write while full is legal only when a pop frees the slot.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = empty ? '0 : mem[rp_q];

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (do_wr) wp_d = wp_q + 1'b1;
    if (do_rd) rp_d = rp_q + 1'b1;
    unique case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dis_pal_capture.sv
// dis_pal_capture: PAL sample capture, one Avalon-ST video
// packet per field with elastic FIFO on the stream side.
module dis_pal_capture
  import dis_pal_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int DIS_X      = PAL_ACTIVE_X,
  parameter int DIS_Y      = PAL_ACTIVE_Y,
  parameter int HSYNC_MIN  = 32,
  parameter int VSYNC_MIN  = 300,
  parameter int FIFO_DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pal_data,
  input  logic                  pal_sync_n,
  input  logic                  pal_blank_n,
  output logic [DATA_WIDTH-1:0] vst_data,
  output logic                  vst_valid,
  input  logic                  vst_ready,
  output logic                  vst_startofpacket,
  output logic                  vst_endofpacket,
  output logic                  frame_drop,
  output logic                  locked
);

  localparam int WW    = DATA_WIDTH + 2;
  localparam int SOP_B = fw_sop_bit(DATA_WIDTH);
  localparam int EOP_B = fw_eop_bit(DATA_WIDTH);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = $clog2(DIS_X + 1);
  localparam int LW    = (DIS_Y > 1) ? $clog2(DIS_Y) : 1;

  // S0: raw pin register
  logic [DATA_WIDTH-1:0] s0_data_q, s0_data_d;
  logic                  s0_sync_q, s0_sync_d;
  logic                  s0_blank_q, s0_blank_d;

  always_comb begin
    s0_data_d  = pal_data;
    s0_sync_d  = pal_sync_n;
    s0_blank_d = pal_blank_n;
  end

  // Sync width measure, classified on the rising edge
  logic [SYNC_CW-1:0] width_q, width_d;
  sync_kind_e         kind;

  always_comb begin
    width_d = width_q;
    kind    = SK_NONE;
    if (!s0_sync_q) begin
      if (width_q != '1) width_d = width_q + 1'b1;
    end else begin
      width_d = '0;
      if (width_q != '0) begin
        kind = classify_sync(width_q, HSYNC_MIN, VSYNC_MIN);
      end
    end
  end

  // S1: sample aligned with its sync classification
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  s1_blank_q, s1_blank_d;
  sync_kind_e            s1_kind_q, s1_kind_d;

  always_comb begin
    s1_data_d  = s0_data_q;
    s1_blank_d = s0_blank_q;
    s1_kind_d  = kind;
  end

  // FIFO
  logic          wr_en;
  logic [WW-1:0] wr_word;
  logic [WW-1:0] rd_word;
  logic [AW:0]   f_usedw;
  logic          f_full, f_empty;
  logic          fifo_room;

  assign fifo_room = (f_usedw < (AW+1)'(FIFO_DEPTH));

  dis_pal_capture_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_word),
    .rd_en   (vst_ready),
    .rd_data (rd_word),
    .usedw   (f_usedw),
    .full    (f_full),
    .empty   (f_empty)
  );

  assign vst_valid         = !f_empty;
  assign vst_data          = rd_word[DATA_WIDTH-1:0];
  assign vst_startofpacket = rd_word[SOP_B];
  assign vst_endofpacket   = rd_word[EOP_B];

  // Field FSM
  cap_state_e    state_q, state_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [LW-1:0] line_q, line_d;
  logic          seen_q, seen_d;
  logic          to_wait_q, to_wait_d;
  logic          locked_q, locked_d;
  logic          drop_q, drop_d;

  logic pix_req, pad_req, last_pix;

  always_comb begin
    state_d   = state_q;
    pix_d     = pix_q;
    line_d    = line_q;
    seen_d    = seen_q;
    to_wait_d = to_wait_q;
    locked_d  = locked_q;
    drop_d    = 1'b0;
    wr_en     = 1'b0;
    wr_word   = '0;

    last_pix = (line_q == LW'(DIS_Y - 1)) &&
               (pix_q == PW'(DIS_X - 1));
    pix_req  = s1_blank_q && (pix_q < PW'(DIS_X));
    // Zero-fill a line whose active part ended early
    pad_req  = !s1_blank_q && seen_q &&
               (pix_q < PW'(DIS_X));

    unique case (state_q)
      ST_HUNT: begin
        if (s1_kind_q == SK_BROAD) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (s1_kind_q == SK_LINE && !f_full) begin
          wr_en          = 1'b1;
          wr_word[SOP_B] = 1'b1;
          pix_d          = '0;
          line_d         = '0;
          seen_d         = 1'b0;
          state_d        = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (s1_kind_q == SK_BROAD) begin
          state_d   = ST_DROP;
          to_wait_d = 1'b1;
          drop_d    = 1'b1;
          locked_d  = 1'b0;
        end else if (s1_kind_q == SK_LINE) begin
          pix_d  = '0;
          seen_d = 1'b0;
          if (line_q != LW'(DIS_Y - 1)) begin
            line_d = line_q + 1'b1;
          end
        end else if (pix_req || pad_req) begin
          if (f_full) begin
            state_d   = ST_DROP;
            to_wait_d = 1'b0;
            drop_d    = 1'b1;
            locked_d  = 1'b0;
          end else begin
            wr_en          = 1'b1;
            wr_word[EOP_B] = last_pix;
            if (pix_req) begin
              wr_word[DATA_WIDTH-1:0] = s1_data_q;
            end
            pix_d  = pix_q + 1'b1;
            seen_d = 1'b1;
            if (last_pix) begin
              locked_d = 1'b1;
              state_d  = ST_HUNT;
            end
          end
        end
      end
      ST_DROP: begin
        if (s1_kind_q == SK_BROAD) to_wait_d = 1'b1;
        if (fifo_room) begin
          wr_en          = 1'b1;
          wr_word[EOP_B] = 1'b1;
          to_wait_d      = 1'b0;
          if (to_wait_q || s1_kind_q == SK_BROAD) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_HUNT;
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  assign frame_drop = drop_q;
  assign locked     = locked_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_data_q  <= '0;
      s0_sync_q  <= 1'b1;
      s0_blank_q <= 1'b0;
      width_q    <= '0;
      s1_data_q  <= '0;
      s1_blank_q <= 1'b0;
      s1_kind_q  <= SK_NONE;
      state_q    <= ST_HUNT;
      pix_q      <= '0;
      line_q     <= '0;
      seen_q     <= 1'b0;
      to_wait_q  <= 1'b0;
      locked_q   <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      s0_data_q  <= s0_data_d;
      s0_sync_q  <= s0_sync_d;
      s0_blank_q <= s0_blank_d;
      width_q    <= width_d;
      s1_data_q  <= s1_data_d;
      s1_blank_q <= s1_blank_d;
      s1_kind_q  <= s1_kind_d;
      state_q    <= state_d;
      pix_q      <= pix_d;
      line_q     <= line_d;
      seen_q     <= seen_d;
      to_wait_q  <= to_wait_d;
      locked_q   <= locked_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_dis_pal_capture.sv
// tb_dis_pal_capture: directed field scenarios with random
// pixel data against a packet-level reference model.
module tb_dis_pal_capture;

  localparam int DW    = 10;
  localparam int DX    = 8;
  localparam int DY    = 3;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] pal_data;
  logic          pal_sync_n;
  logic          pal_blank_n;
  logic [DW-1:0] vst_data;
  logic          vst_valid;
  logic          vst_ready;
  logic          vst_startofpacket;
  logic          vst_endofpacket;
  logic          frame_drop;
  logic          locked;

  always #5 clk = ~clk;

  dis_pal_capture #(
    .DATA_WIDTH (DW),
    .DIS_X      (DX),
    .DIS_Y      (DY),
    .HSYNC_MIN  (32),
    .VSYNC_MIN  (300),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .pal_data          (pal_data),
    .pal_sync_n        (pal_sync_n),
    .pal_blank_n       (pal_blank_n),
    .vst_data          (vst_data),
    .vst_valid         (vst_valid),
    .vst_ready         (vst_ready),
    .vst_startofpacket (vst_startofpacket),
    .vst_endofpacket   (vst_endofpacket),
    .frame_drop        (frame_drop),
    .locked            (locked)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int drops    = 0;
  int first_drv = -1;
  bit grab     = 1'b0;

  logic [11:0]   got_q[$];
  int            got_cyc[$];
  logic [11:0]   exp_q[$];
  logic [DW-1:0] cur_px[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the stream away from the active edge
  always @(negedge clk) begin
    if (vst_valid && vst_ready) begin
      got_q.push_back({vst_startofpacket,
                       vst_endofpacket, vst_data});
      got_cyc.push_back(cyc);
    end
    if (frame_drop) drops++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold(input bit s, input bit b, input int n);
    pal_sync_n  = s;
    pal_blank_n = b;
    repeat (n) begin
      pal_data = DW'($urandom);
      step();
    end
  endtask

  // Reference: header, DX words per line (pixels then zero
  // fill when short, extra samples dropped), EOP on last word.
  task automatic model_hdr();
    exp_q.push_back(12'h800);
  endtask

  task automatic model_line(input bit last);
    int n;
    logic [11:0] w;
    n = (cur_px.size() > DX) ? DX : cur_px.size();
    for (int i = 0; i < DX; i++) begin
      w = '0;
      if (i < n) w[DW-1:0] = cur_px[i];
      if (last && i == DX - 1) w[10] = 1'b1;
      exp_q.push_back(w);
    end
  endtask

  task automatic broad();
    hold(1'b0, 1'b0, 400);
    hold(1'b1, 1'b0, 20);
  endtask

  task automatic line(input int n, input bit last,
                      input bit model);
    cur_px.delete();
    hold(1'b0, 1'b0, 40);
    hold(1'b1, 1'b0, 10);
    for (int i = 0; i < n; i++) begin
      pal_sync_n  = 1'b1;
      pal_blank_n = 1'b1;
      pal_data    = DW'($urandom);
      cur_px.push_back(pal_data);
      if (grab) begin
        first_drv = cyc;
        grab      = 1'b0;
      end
      step();
    end
    hold(1'b1, 1'b0, 12);
    if (model) model_line(last);
  endtask

  task automatic field(input int c0, input int c1,
                       input int c2);
    broad();
    model_hdr();
    line(c0, 1'b0, 1'b1);
    line(c1, 1'b0, 1'b1);
    line(c2, 1'b1, 1'b1);
  endtask

  task automatic drain(input string tag);
    int idle;
    int n;
    idle = 0;
    n    = 0;
    while (idle < 5 && n < 400) begin
      step();
      n++;
      idle = vst_valid ? 0 : idle + 1;
    end
    chk({tag, "_drain"}, 32'(idle >= 5), 32'd1);
  endtask

  task automatic compare(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size();
         i++) begin
      chk($sformatf("%s_w%0d", tag, i), 32'(got_q[i]),
          32'(exp_q[i]));
    end
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    int base;
    int lat;
    rst         = 1'b1;
    vst_ready   = 1'b1;
    pal_sync_n  = 1'b1;
    pal_blank_n = 1'b0;
    pal_data    = '0;
    step(3);
    chk("rst_valid", 32'(vst_valid), 32'd0);
    chk("rst_data", 32'(vst_data), 32'd0);
    chk("rst_sop", 32'(vst_startofpacket), 32'd0);
    chk("rst_eop", 32'(vst_endofpacket), 32'd0);
    chk("rst_drop", 32'(frame_drop), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    rst = 1'b0;
    step(5);

    // Full field, ready high
    base = drops;
    grab = 1'b1;
    field(8, 8, 8);
    drain("f1");
    lat = (got_cyc.size() > 1) ? got_cyc[1] - first_drv : -1;
    chk("latency", 32'(lat), 32'd3);
    compare("f1");
    chk("f1_locked", 32'(locked), 32'd1);
    chk("f1_nodrop", 32'(drops - base), 32'd0);

    // Short line padded with zeros
    field(8, 5, 8);
    drain("f2");
    compare("f2");

    // Random line lengths, overlong lines truncated
    field($urandom_range(1, 10), $urandom_range(1, 10),
          $urandom_range(1, 10));
    drain("f3");
    compare("f3");
    chk("f3_nodrop", 32'(drops - base), 32'd0);

    // Narrow sync pulse ignored
    broad();
    model_hdr();
    line(8, 1'b0, 1'b1);
    hold(1'b0, 1'b0, 20);
    hold(1'b1, 1'b0, 10);
    line(8, 1'b0, 1'b1);
    line(8, 1'b1, 1'b1);
    drain("f4");
    compare("f4");
    chk("f4_locked", 32'(locked), 32'd1);

    // Backpressure overflow
    base      = drops;
    vst_ready = 1'b0;
    field(8, 8, 8);
    step(20);
    chk("ovf_drop", 32'(drops - base), 32'd1);
    chk("ovf_locked", 32'(locked), 32'd0);
    chk("ovf_held", 32'(got_q.size()), 32'd0);
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    exp_q.push_back(12'h400);
    vst_ready = 1'b1;
    drain("ovf");
    compare("ovf");

    // Broad pulse mid-field, then recapture from WAIT
    base = drops;
    broad();
    model_hdr();
    line(8, 1'b0, 1'b1);
    broad();
    exp_q.push_back(12'h400);
    chk("trunc_drop", 32'(drops - base), 32'd1);
    model_hdr();
    line(8, 1'b0, 1'b1);
    line(8, 1'b0, 1'b1);
    line(8, 1'b1, 1'b1);
    drain("trunc");
    compare("trunc");
    chk("trunc_locked", 32'(locked), 32'd1);

    // Reset mid-packet
    vst_ready = 1'b0;
    broad();
    line(8, 1'b0, 1'b0);
    chk("mid_valid", 32'(vst_valid), 32'd1);
    rst = 1'b1;
    step();
    chk("mr_valid", 32'(vst_valid), 32'd0);
    chk("mr_data", 32'(vst_data), 32'd0);
    chk("mr_sop", 32'(vst_startofpacket), 32'd0);
    chk("mr_eop", 32'(vst_endofpacket), 32'd0);
    chk("mr_drop", 32'(frame_drop), 32'd0);
    chk("mr_locked", 32'(locked), 32'd0);
    rst       = 1'b0;
    vst_ready = 1'b1;
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    line(8, 1'b0, 1'b0);
    line(8, 1'b1, 1'b0);
    drain("mr_hunt");
    chk("mr_silent", 32'(got_q.size()), 32'd0);
    field(8, 8, 8);
    drain("mr");
    compare("mr");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
